// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_pkg
// Purpose  : Shared constants and types for the store buffer unit: store
//            opcodes, access-size encoding (bytes), the queued entry layout
//            and a helper mapping an access size to its unshifted byte mask.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package store_pkg;

    // MIPS store opcodes, instruction[31:26]
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;
    localparam logic [5:0] OP_SD = 6'h3F;

    // Access size in bytes
    localparam logic [3:0] SIZE_B = 4'd1;
    localparam logic [3:0] SIZE_H = 4'd2;
    localparam logic [3:0] SIZE_W = 4'd4;
    localparam logic [3:0] SIZE_D = 4'd8;

    // Queued store, held at the widest legal configuration; the top level
    // packs only the ADDR_W / DATA_W / DATA_W/8 low bits into the FIFO.
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } sb_entry_t;

    // Byte mask for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_to_be(input logic [3:0] size);
        logic [7:0] be;
        case (size)
            SIZE_B:  be = 8'h01;
            SIZE_H:  be = 8'h03;
            SIZE_W:  be = 8'h0F;
            SIZE_D:  be = 8'hFF;
            default: be = 8'h00;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
// Module   : store_fifo
// Purpose  : Parametrised synchronous FIFO used as the store buffer.
//            Storage is not reset; occupancy is tracked by count so stale
//            words are never presented as valid.
// Ports    : clk      - clock
//            reset    - synchronous active-low reset (pointers/count to 0)
//            push_i   - write wdata_i (ignored when full)
//            wdata_i  - entry to enqueue
//            pop_i    - drop head (ignored when empty)
//            rdata_o  - head entry (storage read at read pointer)
//            count_o  - occupied entries
//            full_o   - count == DEPTH
//            empty_o  - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module store_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_MAX = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]   count_q, count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o    = (count_q == c_CNT_MAX);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = w_do_push ? wr_ptr_q + c_PTR_ONE : wr_ptr_q;
        rd_ptr_d = w_do_pop  ? rd_ptr_q + c_PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_unit
// Purpose  : Store execution stage. Decodes SB/SH/SW(/SD), forms the
//            effective address base + sext(imm16), lane-aligns store data
//            with byte enables and queues the result in a DEPTH-entry FIFO
//            that drains to data memory over MemWrite/mem_ready.
// Config   : `define STORE_MISALIGN_TRAP_EN -> misaligned stores are dropped
//            and flagged on misalign_err; otherwise they are force-aligned.
// Ports    : clk, reset (sync, active-low)
//            instr_valid / instr_ready      - instruction handshake
//            instruction, Read_data1/2      - opcode+imm16, base, store data
//            MemWrite / mem_ready           - head entry handshake to memory
//            ALU_result, Write_data, Byte_en- head entry (0 when empty)
//            buf_count                      - occupied entries
//            misalign_err                   - one-cycle misalignment pulse
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer_unit
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [31:0]              instruction,
    input  logic [ADDR_W-1:0]        Read_data1,
    input  logic [DATA_W-1:0]        Read_data2,
    output logic                     MemWrite,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        ALU_result,
    output logic [DATA_W-1:0]        Write_data,
    output logic [DATA_W/8-1:0]      Byte_en,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     misalign_err
);

    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_BE_W);
    localparam int c_ENT_W = ADDR_W + DATA_W + c_BE_W;

    logic [5:0]          w_opcode;
    logic                w_is_store;
    logic [3:0]          w_size;
    logic [ADDR_W-1:0]   w_imm_ext;
    logic [ADDR_W-1:0]   w_raw_addr;
    logic [ADDR_W-1:0]   w_addr;
    logic [c_OFF_W-1:0]  w_align_mask;
    logic [c_OFF_W-1:0]  w_off;
    logic                w_misaligned;
    logic [c_BE_W-1:0]   w_be_base;
    logic [c_BE_W-1:0]   w_be;
    logic [DATA_W-1:0]   w_data_masked;
    logic [DATA_W-1:0]   w_data;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    sb_entry_t           w_entry;
    logic [c_ENT_W-1:0]  w_push_data;
    logic [c_ENT_W-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_unused;

    // ---------------- decode ----------------
    always_comb begin
        w_opcode   = instruction[31:26];
        w_is_store = 1'b0;
        w_size     = 4'd0;
        case (w_opcode)
            OP_SB: begin w_is_store = 1'b1; w_size = SIZE_B; end
            OP_SH: begin w_is_store = 1'b1; w_size = SIZE_H; end
            OP_SW: begin w_is_store = 1'b1; w_size = SIZE_W; end
            OP_SD: begin
                // Doubleword only exists on a 64-bit data path.
                if (DATA_W == 64) begin
                    w_is_store = 1'b1;
                    w_size     = SIZE_D;
                end
            end
            default: begin
                w_is_store = 1'b0;
                w_size     = 4'd0;
            end
        endcase
    end

    // ---------------- address generation ----------------
    assign w_imm_ext    = {{(ADDR_W-16){instruction[15]}}, instruction[15:0]};
    assign w_raw_addr   = Read_data1 + w_imm_ext;
    // size-1 equals the low-address bits that must be zero for alignment
    assign w_align_mask = c_OFF_W'(w_size - 4'd1);
    assign w_misaligned = |(w_raw_addr[c_OFF_W-1:0] & w_align_mask);

    always_comb begin
        w_addr = w_raw_addr;
`ifndef STORE_MISALIGN_TRAP_EN
        w_addr[c_OFF_W-1:0] = w_raw_addr[c_OFF_W-1:0] & ~w_align_mask;
`endif
    end

    assign w_off = w_addr[c_OFF_W-1:0];

    // ---------------- lane alignment ----------------
    assign w_be_base = c_BE_W'(size_to_be(w_size));

    always_comb begin
        w_data_masked = '0;
        for (int i = 0; i < c_BE_W; i++) begin
            w_data_masked[i*8 +: 8] = w_be_base[i] ? Read_data2[i*8 +: 8] : 8'h00;
        end
    end

    assign w_data = w_data_masked << {w_off, 3'b000};
    assign w_be   = w_be_base << w_off;

    // ---------------- enqueue / dequeue ----------------
    assign w_accept = instr_valid && instr_ready;
`ifdef STORE_MISALIGN_TRAP_EN
    assign w_push   = w_accept && w_is_store && !w_misaligned;
`else
    assign w_push   = w_accept && w_is_store;
`endif
    assign w_pop    = MemWrite && mem_ready;

    always_comb begin
        w_entry      = '0;
        w_entry.addr = 64'(w_addr);
        w_entry.data = 64'(w_data);
        w_entry.be   = 8'(w_be);
    end

    assign w_push_data = {w_entry.addr[ADDR_W-1:0],
                          w_entry.data[DATA_W-1:0],
                          w_entry.be[c_BE_W-1:0]};

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .wdata_i (w_push_data),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (buf_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Ready ignores mem_ready: a full buffer never accepts alongside a pop.
    assign instr_ready = !w_full;
    assign MemWrite    = !w_empty;
    assign ALU_result  = w_empty ? '0 : w_head[c_ENT_W-1 -: ADDR_W];
    assign Write_data  = w_empty ? '0 : w_head[c_BE_W +: DATA_W];
    assign Byte_en     = w_empty ? '0 : w_head[c_BE_W-1:0];

    // ---------------- misalignment reporting ----------------
`ifdef STORE_MISALIGN_TRAP_EN
    logic misalign_q;
    logic misalign_d;

    assign misalign_d = w_accept && w_is_store && w_misaligned;

    always_ff @(posedge clk) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    // Register-specifier fields and the wide entry padding are not needed.
    assign w_unused = ^{instruction[25:16], w_entry, w_misaligned};

endmodule
`default_nettype wire

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
Parametrised store-execution stage. Decodes SB/SH/SW(/SD) instructions, computes the effective address as base plus sign-extended imm16, and lane-aligns store data with byte enables. Queues the results in a DEPTH-entry FIFO that drains to data memory over a valid/ready handshake. Sits between the register-file read outputs and the data memory, replacing the single-cycle store path.

Parameters:
DATA_W, 32, memory data width; legal values 32 or 64.
ADDR_W, 32, address width; address arithmetic is modulo 2^ADDR_W.
DEPTH, 4, store-buffer entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
instr_valid  in  1  instruction and operands valid this cycle.
instr_ready  out  1  unit can accept this cycle.
instruction  in  32  MIPS I-format: [31:26] opcode, [15:0] imm16.
Read_data1  in  ADDR_W  base register value.
Read_data2  in  DATA_W  store data register value.
MemWrite  out  1  memory write request valid; head entry presented.
mem_ready  in  1  memory accepts the head entry.
ALU_result  out  ADDR_W  effective address of the head entry.
Write_data  out  DATA_W  lane-aligned data of the head entry.
Byte_en  out  DATA_W/8  byte enables of the head entry.
buf_count  out  $clog2(DEPTH)+1  number of occupied entries.
misalign_err  out  1  one-cycle error pulse (see Optional Feature).

Behaviour:
- Reset (reset==0 at a rising edge): pointers and count go to 0. MemWrite, ALU_result, Write_data, Byte_en and misalign_err go to 0. Buffered entries are discarded, including any entry mid-handshake.
- Accept: an instruction is accepted when instr_valid && instr_ready at the edge.
- instr_ready = (buf_count < DEPTH). It does not depend on mem_ready, so a full buffer never accepts in the same cycle as a pop.
- Opcodes: 0x28 SB, 0x29 SH, 0x2B SW, 0x3F SD (DATA_W==64 only). Any other opcode, including SD when DATA_W==32, is accepted and dropped with no entry and no error.
- Address: addr = Read_data1 + sign_extend(imm16), truncated to ADDR_W. Lane offset = addr[log2(DATA_W/8)-1:0].
- Data placement (little-endian): size bytes of Read_data2[size*8-1:0] are shifted left by offset*8. Byte_en = ((1<<size)-1) << offset. Unused lanes of Write_data are 0.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (MemWrite=1) if the buffer was empty.
- Head outputs are registered from FIFO storage. MemWrite = (buf_count != 0). When empty, ALU_result, Write_data and Byte_en are held at 0.
- Pop: the head is popped on an edge where MemWrite && mem_ready. The head stays stable while MemWrite && !mem_ready.
- Simultaneous push and pop while not full: count is unchanged, and both pointers advance (wrap at DEPTH).
- Ordering is strict FIFO; there is no coalescing or forwarding.

Optional Feature:
Macro: STORE_MISALIGN_TRAP_EN.
- Defined: a store whose offset is not a multiple of its size creates no entry. misalign_err pulses high for exactly the cycle after the accepting edge.
- Undefined: a misaligned address is force-aligned by clearing its low log2(size) bits before the entry is written. misalign_err is tied to 0.

Decomposition:
- Package store_pkg: opcode constants OP_SB/OP_SH/OP_SW/OP_SD; size encoding (1/2/4/8 bytes); entry struct {addr, data, be}.
- One sub-module: store_fifo. It is a parametrised synchronous FIFO (DEPTH, entry width), provides count, full and empty, and is reset by the same active-low synchronous reset.
- Decode, address generation and lane alignment stay in the top level.

Test Plan:
1. SW: instruction=32'hAC000004, Read_data1=0x10, Read_data2=0x0000000B, mem_ready=1 -> next cycle MemWrite=1, ALU_result=0x14, Write_data=0x0000000B, Byte_en=4'b1111; count back to 0 after the following edge.
2. SB/SH lanes (DATA_W=32):
   - 32'hA0000003, Read_data1=0x10, Read_data2=0xAB -> ALU_result=0x13, Write_data=0xAB000000, Byte_en=4'b1000.
   - 32'hA4000002, Read_data2=0x1234 -> ALU_result=0x12, Write_data=0x12340000, Byte_en=4'b1100.
3. Negative offset and wrap:
   - imm=0xFFFC, Read_data1=0x10 -> ALU_result=0x0C.
   - imm=0xFFFF, Read_data1=0x0 -> ALU_result=0xFFFFFFFF (SB, Byte_en=4'b1000).
4. Full/backpressure: mem_ready=0, four SW to 0x0/0x4/0x8/0xC -> buf_count=4, instr_ready=0, head stays 0x0. Then mem_ready=1 -> drains in order 0x0,0x4,0x8,0xC over 4 cycles; instr_ready returns 1 after the first pop.
5. Misaligned SW, Read_data1=0x12, imm=0:
   - With macro: no entry, buf_count stays 0, misalign_err=1 for one cycle.
   - Without macro: entry with ALU_result=0x10, Byte_en=4'b1111.
6. Reset mid-operation: 3 entries queued, mem_ready=0, reset=0 for one edge -> buf_count=0, MemWrite=0, outputs 0. A non-store opcode 0x8C000000 (LW) is accepted with no entry.
